// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the response channel and busy status
// exchanged between the shared ALU arbiter and its clients.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [3:0]            req0_op;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [3:0]            req1_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic [2:0]            resp_flags;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_flags, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; a single operation is
// in flight at a time and moves through IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         resetn,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_SLTU = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SAL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;

  // Returns {overflow, carry_out, zero, result}.
  function automatic logic [DATA_WIDTH+2:0] alu_exec(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0]        res;
    logic [DATA_WIDTH:0]          sum;
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic                         co;
    logic                         ov;
    logic                         z_en;
    res  = '0;
    sum  = '0;
    co   = 1'b0;
    ov   = 1'b0;
    z_en = 1'b0;
    sa   = a;
    sb   = b;
    case (op)
      OP_AND:  begin res = a & b;    z_en = 1'b1; end
      OP_OR:   begin res = a | b;    z_en = 1'b1; end
      OP_XOR:  begin res = a ^ b;    z_en = 1'b1; end
      OP_NOR:  begin res = ~(a | b); z_en = 1'b1; end
      OP_ADD, OP_SUB: begin
        // SUB is A + ~B + 1 so both share the same carry/overflow derivation.
        if (op == OP_ADD) sum = {1'b0, a} + {1'b0, b};
        else              sum = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
        res  = sum[DATA_WIDTH-1:0];
        co   = sum[DATA_WIDTH];
        ov   = (a[DATA_WIDTH-1] ^ ((op == OP_ADD) ? b[DATA_WIDTH-1] : ~b[DATA_WIDTH-1])
                ^ res[DATA_WIDTH-1]) ^ co;
        z_en = 1'b1;
      end
      OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res = b << a[4:0];
      OP_SRL:  res = b >> a[4:0];
      OP_SRA:  res = sb >>> a[4:0];
      OP_SAL:  res = (a >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (b << a);
      OP_LUI:  res = DATA_WIDTH'({b[15:0], 16'h0000});
      default: res = '0;
    endcase
    return {ov, co, (z_en && (res == '0)), res};
  endfunction

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  busy_q, busy_d;
  logic                  resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic [2:0]            resp_flags_q, resp_flags_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]            op_q, op_d;
  logic                  id_q, id_d;
  logic                  grant;
  logic                  ready0;
  logic                  ready1;
  logic                  accept;
  logic [DATA_WIDTH+2:0] alu_out;

  // Requester 1 wins when alone, or when both ask and requester 0 went last.
  assign grant  = bus.req1_valid && (!bus.req0_valid || !last_q);
  assign ready0 = resetn && (state_q == IDLE) && !grant;
  assign ready1 = resetn && (state_q == IDLE) && grant;
  assign accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
  assign alu_out = alu_exec(op_q, a_q, b_q);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    resp_valid_d  = resp_valid_q;
    busy_d        = busy_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          busy_d  = 1'b1;
          last_d  = grant;
          id_d    = grant;
          a_d     = grant ? bus.req1_a  : bus.req0_a;
          b_d     = grant ? bus.req1_b  : bus.req0_b;
          op_d    = grant ? bus.req1_op : bus.req0_op;
        end
      end
      EXEC: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_result_d = alu_out[DATA_WIDTH-1:0];
        resp_flags_d  = alu_out[DATA_WIDTH+2:DATA_WIDTH];
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      resp_valid_q  <= resp_valid_d;
      busy_q        <= busy_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  // Operand capture is datapath only; its content is irrelevant until accepted.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
    id_q <= id_d;
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flags  = resp_flags_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-op results/flags, round-robin order,
// response backpressure and reset abort, all against hand-computed values.
module tb_alu_arbiter;
  localparam int DATA_WIDTH = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  alu_arbiter #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int vec_cnt     = 0;
  int miscmp_cnt  = 0;
  int acc_k[$];
  int acc_id[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit id, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // One complete transaction from IDLE with resp_ready held high.
  task automatic run_op(input string tag, input bit id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [2:0] exp_f);
    @(negedge clk);
    drive(id, 1'b1, op, a, b);
    #1;
    chk({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1'b1);
    @(negedge clk);
    drive(id, 1'b0, ~op, ~a, ~b);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_early_valid"}, bus.resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, bus.resp_valid, 1'b1);
    chk({tag, "_id"}, bus.resp_id, id);
    chk({tag, "_result"}, bus.resp_result, exp_r);
    chk({tag, "_flags"}, bus.resp_flags, exp_f);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    bus.resp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'h2, 32'h1, 32'h1);
    drive(1'b1, 1'b1, 4'h2, 32'h1, 32'h1);

    // Reset state, with both requesters valid to show readies are gated.
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.resp_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_result", bus.resp_result, 32'h0);
    chk("rst_flags", bus.resp_flags, 3'b000);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;

    run_op("add_ovf",  1'b0, 4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b100);
    run_op("add_cry",  1'b0, 4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b011);
    run_op("sub_eq",   1'b1, 4'h3, 32'h00000005, 32'h00000005, 32'h00000000, 3'b011);
    run_op("sub_neg",  1'b0, 4'h3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3'b000);
    run_op("sub_ovf",  1'b1, 4'h3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b110);
    run_op("and",      1'b0, 4'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 3'b000);
    run_op("or",       1'b1, 4'h1, 32'hF0000000, 32'h0000000F, 32'hF000000F, 3'b000);
    run_op("xor_zero", 1'b0, 4'hB, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 3'b001);
    run_op("nor",      1'b1, 4'hC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b000);
    run_op("slt",      1'b0, 4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000);
    run_op("sltu",     1'b1, 4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b000);
    run_op("sll_wrap", 1'b0, 4'h6, 32'h00000024, 32'h00000001, 32'h00000010, 3'b000);
    run_op("srl",      1'b1, 4'h7, 32'h00000004, 32'h80000000, 32'h08000000, 3'b000);
    run_op("sra",      1'b0, 4'h9, 32'h00000004, 32'h80000000, 32'hF8000000, 3'b000);
    run_op("sal_31",   1'b1, 4'h8, 32'h0000001F, 32'h00000001, 32'h80000000, 3'b000);
    run_op("sal_big",  1'b0, 4'h8, 32'h00000024, 32'h00000001, 32'h00000000, 3'b000);
    run_op("lui",      1'b1, 4'hA, 32'h00000000, 32'h1234ABCD, 32'hABCD0000, 3'b000);
    run_op("op_f",     1'b0, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b000);

    // Round robin: both valid straight out of reset.
    @(negedge clk);
    resetn = 1'b0;
    drive(1'b0, 1'b1, 4'h2, 32'h1, 32'h1);
    drive(1'b1, 1'b1, 4'h3, 32'h9, 32'h4);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.req0_ready && bus.req0_valid) begin acc_k.push_back(k); acc_id.push_back(0); end
      if (bus.req1_ready && bus.req1_valid) begin acc_k.push_back(k); acc_id.push_back(1); end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rr_count", acc_k.size(), 4);
    for (int i = 0; i < 4 && i < acc_k.size(); i++) begin
      chk($sformatf("rr_id%0d", i), acc_id[i], i % 2);
      chk($sformatf("rr_cycle%0d", i), acc_k[i], 3 * i);
    end

    // Backpressure: req1 ADD 2+3 held in RESP while req0 waits.
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h2, 32'h2, 32'h3);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 4'h0, 32'hFFFF0000, 32'h0F0F0F0F);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", bus.resp_valid, 1'b1);
      chk("bp_result", bus.resp_result, 32'h5);
      chk("bp_id", bus.resp_id, 1'b1);
      chk("bp_ready0", bus.req0_ready, 1'b0);
      chk("bp_ready1", bus.req1_ready, 1'b0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ret_busy", bus.busy, 1'b0);
    chk("bp_ret_valid", bus.resp_valid, 1'b0);
    chk("bp_ret_ready0", bus.req0_ready, 1'b1);
    @(negedge clk);
    chk("bp_new_busy", bus.busy, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bp_new_result", bus.resp_result, 32'h0F0F0000);
    chk("bp_new_id", bus.resp_id, 1'b0);
    @(negedge clk);

    // Reset during EXEC of a req1 operation.
    drive(1'b1, 1'b1, 4'h2, 32'h1, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ra_busy_pre", bus.busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("ra_busy", bus.busy, 1'b0);
    chk("ra_valid", bus.resp_valid, 1'b0);
    chk("ra_result", bus.resp_result, 32'h0);
    chk("ra_flags", bus.resp_flags, 3'b000);
    chk("ra_ready1", bus.req1_ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ra_no_resp", bus.resp_valid, 1'b0);
    end
    drive(1'b0, 1'b1, 4'h1, 32'h1, 32'h2);
    drive(1'b1, 1'b1, 4'h1, 32'h4, 32'h8);
    #1;
    chk("ra_grant0", bus.req0_ready, 1'b1);
    chk("ra_grant1", bus.req1_ready, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ra_after_id", bus.resp_id, 1'b0);
    chk("ra_after_result", bus.resp_result, 32'h3);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the operand and result width.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 operation valid.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  DATA_WIDTH  operand A.
- req0_b  in  DATA_WIDTH  operand B.
- req0_op  in  4  ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  index of the requester that issued the operation.
- resp_result  out  DATA_WIDTH  ALU result.
- resp_flags  out  3  {Overflow, CarryOut, Zero}.
- busy  out  1  high when state != IDLE.

Function
REQ-003 The block SHALL contain one ALU datapath shared by both requesters, with one operation in flight at most.
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP, with the transitions below.
- IDLE->EXEC on an accept handshake.
- EXEC->RESP unconditionally after one cycle.
- RESP->IDLE on resp_valid&&resp_ready.
REQ-005 The reqN_ready outputs SHALL be combinational and equal (state==IDLE && grant==N); both SHALL be 0 in EXEC and RESP.
REQ-006 Grant SHALL follow round-robin arbitration.
- Only one valid: that requester is granted.
- Both valid: the requester not granted last is granted.
- The last-grant pointer updates only on an accept handshake.
REQ-007 On accept, the block SHALL register A, B, op and id; the requester may change its inputs afterwards.
REQ-008 In EXEC, the block SHALL compute from the registered operands and register result and flags at the end of the cycle.
REQ-009 Latency: resp_valid SHALL rise after the second rising edge following the accept edge; minimum issue interval is 3 cycles.
REQ-010 In RESP, resp_valid SHALL be 1, and resp_id, resp_result and resp_flags SHALL remain stable until the handshake.
REQ-011 Op codes and results SHALL be as follows.
- 0 AND, 1 OR, 2 ADD, 3 SUB, B XOR, C NOR.
- 4 SLT (signed), 5 SLTU: result is 1 or 0.
- 6 SLL: B<<A[4:0]. 7 SRL: B>>A[4:0]. 9 SRA: B arithmetically >> A[4:0].
- 8 SAL: B<<A using full-width A; A>=32 yields 0.
- A LUI: {B[15:0],16'h0}.
- D-F: result 0.
REQ-012 Flags SHALL be set as follows.
- Zero = (result==0) for AND, OR, ADD, SUB, XOR, NOR; 0 for all other ops.
- ADD CarryOut = carry out of A+B. SUB CarryOut = carry out of A+~B+1.
- ADD/SUB Overflow = carry into MSB XOR carry out of MSB.
- All other ops: Overflow = CarryOut = 0.
REQ-013 A new request SHALL NOT be accepted in the same cycle as a response handshake; the block returns to IDLE first.

Reset
REQ-014 When resetn=0, the block SHALL immediately force the following, regardless of the clock.
- state=IDLE, resp_valid=0, busy=0.
- resp_id=0, resp_result=0, resp_flags=0.
- The last-grant pointer set so that requester 0 wins the first contention.
REQ-015 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL appear after release.
REQ-016 While resetn=0, reqN_ready SHALL be 0.

Verification
REQ-017 ADD: req0 only, op=2, A=32'h7FFFFFFF, B=1 -> resp_id=0, resp_result=32'h80000000, flags=3'b100, resp_valid 2 edges after accept.
REQ-018 SUB/SLT/SRA checks:
- SUB A=5, B=5 -> result 0, flags=3'b011.
- SLT A=32'hFFFFFFFF, B=1 -> result 1.
- SRA A=4, B=32'h80000000 -> result 32'hF8000000, flags 0.
REQ-019 Both requesters continuously valid from reset, resp_ready=1 -> grant order 0,1,0,1 with one accept every 3 cycles.
REQ-020 resp_ready held low 5 cycles in RESP -> resp_valid and data stable, both readies 0; on resp_ready=1, IDLE next cycle, then a new accept.
REQ-021 resetn pulsed low during EXEC of a req1 operation -> outputs clear immediately, no response after release, next contention granted to req0.
REQ-022 op=4'hF, A=B=32'hFFFFFFFF -> resp_result=0, flags=0.
